// File: rtl/stream_pkg.sv
// Shared types and elaboration-time helpers for the stream arbiter slice.
package stream_pkg;

    typedef enum logic [1:0] {
        ARBITRATE,
        ACCEPT,
        SEND
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Index fields never collapse to zero bits, even for a single channel.
    function automatic int unsigned index_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_arbiter_if.sv
// Bundle of the N input streams and the merged output stream of stream_arbiter.
interface stream_arbiter_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned CW = stream_pkg::index_width(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] input_data;
    logic [CHANNELS-1:0]       input_stb;
    logic [CHANNELS-1:0]       input_ack;
    logic [WIDTH-1:0]          output_data;
    logic [CW-1:0]             output_channel;
    logic                      output_stb;
    logic                      output_ack;

    modport master (
        output input_data, input_stb, output_ack,
        input  input_ack, output_data, output_channel, output_stb
    );

    modport slave (
        input  input_data, input_stb, output_ack,
        output input_ack, output_data, output_channel, output_stb
    );

endinterface

// File: rtl/stream_rr_select.sv
// Combinational round-robin picker: first requesting channel at or after pointer.
module stream_rr_select #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CW       = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [CW-1:0]       pointer,
    output logic                found,
    output logic [CW-1:0]       sel
);

    logic [2*CHANNELS-1:0] rotated;
    int unsigned           index;

    // Rotating the doubled request vector puts the pointer channel at bit 0;
    // scanning downwards lets the nearest requester win.
    always_comb begin
        rotated = {req, req} >> pointer;
        found   = 1'b0;
        sel     = '0;
        index   = 0;
        for (int unsigned i = CHANNELS; i > 0; i--) begin
            if (rotated[i-1]) begin
                index = 32'(pointer) + i - 1;
                if (index >= CHANNELS) begin
                    index = index - CHANNELS;
                end
                found = 1'b1;
                sel   = CW'(index);
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin N-to-1 merge of stb/ack word streams with per-grant burst limit.
module stream_arbiter
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned BURST    = 1
) (
    input logic            clk,
    input logic            rst,
    stream_arbiter_if.slave bus
);

    localparam int unsigned CW = index_width(CHANNELS);
    localparam int unsigned BW = index_width(BURST + 1);

    state_t         state;
    logic [CW-1:0]  pointer;
    logic [CW-1:0]  sel;
    logic [BW-1:0]  count;

    logic           found;
    logic [CW-1:0]  pick;
    logic           sel_stb;
    logic [WIDTH-1:0] sel_data;
    logic [CW-1:0]  next_pointer;

    stream_rr_select #(
        .CHANNELS(CHANNELS),
        .CW      (CW)
    ) u_select (
        .req    (bus.input_stb),
        .pointer(pointer),
        .found  (found),
        .sel    (pick)
    );

    always_comb begin
        sel_stb  = 1'b0;
        sel_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (CW'(k) == sel) begin
                sel_stb  = bus.input_stb[k];
                sel_data = bus.input_data[k*WIDTH +: WIDTH];
            end
        end
        next_pointer = (sel == CW'(CHANNELS - 1)) ? '0 : sel + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ARBITRATE;
            pointer            <= '0;
            sel                <= '0;
            count              <= '0;
            bus.input_ack      <= '0;
            bus.output_stb     <= 1'b0;
            bus.output_data    <= '0;
            bus.output_channel <= '0;
        end else begin
            case (state)
                ARBITRATE: begin
                    if (found) begin
                        sel <= pick;
                        for (int unsigned k = 0; k < CHANNELS; k++) begin
                            bus.input_ack[k] <= (CW'(k) == pick);
                        end
                        state <= ACCEPT;
                    end
                end
                // A withdrawn request keeps the grant; nothing else is served meanwhile.
                ACCEPT: begin
                    if (sel_stb) begin
                        bus.output_data    <= sel_data;
                        bus.output_channel <= sel;
                        bus.output_stb     <= 1'b1;
                        bus.input_ack      <= '0;
                        count              <= count + BW'(1);
                        state              <= SEND;
                    end
                end
                SEND: begin
                    if (bus.output_ack) begin
                        bus.output_stb <= 1'b0;
                        if ((count < BW'(BURST)) && sel_stb) begin
                            for (int unsigned k = 0; k < CHANNELS; k++) begin
                                bus.input_ack[k] <= (CW'(k) == sel);
                            end
                            state <= ACCEPT;
                        end else begin
                            pointer <= next_pointer;
                            count   <= '0;
                            state   <= ARBITRATE;
                        end
                    end
                end
                default: state <= ARBITRATE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench: two arbiters (BURST=1 and BURST=3) against a queue-based model.
module tb_stream_arbiter;

    localparam int W = 32;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stream_arbiter_if #(.WIDTH(W), .CHANNELS(C)) b1 ();
    stream_arbiter_if #(.WIDTH(W), .CHANNELS(C)) b3 ();

    stream_arbiter #(.WIDTH(W), .CHANNELS(C), .BURST(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );
    stream_arbiter #(.WIDTH(W), .CHANNELS(C), .BURST(3)) dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave)
    );

    int checks = 0;
    int errors = 0;

    // Producer queues indexed d*C+k; d=0 feeds the BURST=1 unit, d=1 the BURST=3 unit.
    logic [W-1:0] pq [2*C][$];
    logic [W-1:0] sw [2*C][$];
    bit           en [2*C];
    logic         oack [2];
    int           rx_ch [2][$];
    logic [W-1:0] rx_dat [2][$];
    bit           hold [2];
    logic [W-1:0] hold_dat [2];
    int           hold_ch [2];

    task automatic step();
        logic [C-1:0]   stb_v [2];
        logic [C*W-1:0] dat_v [2];
        logic [C-1:0]   iack [2];
        logic           ostb [2];
        logic [W-1:0]   odat [2];
        int             och [2];
        iack[0] = b1.input_ack; ostb[0] = b1.output_stb;
        odat[0] = b1.output_data; och[0] = int'(b1.output_channel);
        iack[1] = b3.input_ack; ostb[1] = b3.output_stb;
        odat[1] = b3.output_data; och[1] = int'(b3.output_channel);
        for (int d = 0; d < 2; d++) begin
            stb_v[d] = '0;
            dat_v[d] = '0;
            for (int k = 0; k < C; k++) begin
                if (pq[d*C+k].size() > 0) begin
                    dat_v[d][k*W +: W] = pq[d*C+k][0];
                    stb_v[d][k] = en[d*C+k];
                end
            end
            if (!rst) begin
                checks++;
                if (!$onehot0(iack[d])) begin
                    errors++;
                    $display("FAIL ack_onehot dut%0d: input_ack=%b, need at most one bit", d, iack[d]);
                end
                if (hold[d]) begin
                    checks++;
                    if (ostb[d] !== 1'b1 || odat[d] !== hold_dat[d] || och[d] != hold_ch[d]) begin
                        errors++;
                        $display("FAIL hold_stable dut%0d: stb=%b data=%h ch=%0d, need 1 %h %0d",
                                 d, ostb[d], odat[d], och[d], hold_dat[d], hold_ch[d]);
                    end
                end
                for (int k = 0; k < C; k++) begin
                    if (stb_v[d][k] && iack[d][k]) void'(pq[d*C+k].pop_front());
                end
                if (ostb[d] && oack[d]) begin
                    rx_ch[d].push_back(och[d]);
                    rx_dat[d].push_back(odat[d]);
                end
                hold[d]     = ostb[d] && !oack[d];
                hold_dat[d] = odat[d];
                hold_ch[d]  = och[d];
            end else begin
                hold[d] = 1'b0;
            end
        end
        b1.input_stb = stb_v[0]; b1.input_data = dat_v[0]; b1.output_ack = oack[0];
        b3.input_stb = stb_v[1]; b3.input_data = dat_v[1]; b3.output_ack = oack[1];
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_all();
        for (int i = 0; i < 2*C; i++) begin
            pq[i].delete();
            sw[i].delete();
            en[i] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            rx_ch[d].delete();
            rx_dat[d].delete();
            oack[d] = 1'b0;
            hold[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_until(input int d, input int n, input int budget, input string name);
        int cyc = 0;
        while (rx_ch[d].size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        checks++;
        if (rx_ch[d].size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words, need %0d", name, rx_ch[d].size(), n);
        end
    endtask

    task automatic test_reset();
        int cyc;
        do_reset();
        checks += 5;
        if (b1.input_ack !== '0) begin errors++; $display("FAIL rst_ack: got %b, need 0", b1.input_ack); end
        if (b1.output_stb !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b, need 0", b1.output_stb); end
        if (b1.output_data !== '0) begin errors++; $display("FAIL rst_data: got %h, need 0", b1.output_data); end
        if (b1.output_channel !== '0) begin errors++; $display("FAIL rst_channel: got %0d, need 0", b1.output_channel); end
        if (b3.output_stb !== 1'b0) begin errors++; $display("FAIL rst_stb3: got %b, need 0", b3.output_stb); end

        pq[1].push_back(32'h1234_5678);
        en[1] = 1'b1;
        cyc = 0;
        while (b1.output_stb !== 1'b1 && cyc < 10) begin step(); cyc++; end
        checks++;
        if (b1.output_stb !== 1'b1) begin errors++; $display("FAIL rst_send_timeout: output_stb=%b, need 1", b1.output_stb); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks += 3;
        if (b1.output_stb !== 1'b0) begin errors++; $display("FAIL midsend_stb: got %b, need 0", b1.output_stb); end
        if (b1.input_ack !== '0) begin errors++; $display("FAIL midsend_ack: got %b, need 0", b1.input_ack); end
        if (b1.output_channel !== '0) begin errors++; $display("FAIL midsend_channel: got %0d, need 0", b1.output_channel); end
        clear_all();
        pq[2].push_back(32'hCAFE_0002);
        en[2] = 1'b1;
        oack[0] = 1'b1;
        run_until(0, 1, 20, "post_reset");
        if (rx_ch[0].size() >= 1) begin
            checks++;
            if (rx_ch[0][0] != 2 || rx_dat[0][0] !== 32'hCAFE_0002) begin
                errors++;
                $display("FAIL post_reset_grant: ch=%0d data=%h, need 2 cafe0002", rx_ch[0][0], rx_dat[0][0]);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        pq[1].push_back(32'h0000_00A5);
        en[1] = 1'b1;
        oack[0] = 1'b1;
        step();
        checks += 2;
        if (b1.input_ack !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b, need 0010", b1.input_ack); end
        if (b1.output_stb !== 1'b0) begin errors++; $display("FAIL single_early_stb: got %b, need 0", b1.output_stb); end
        step();
        checks += 4;
        if (b1.output_stb !== 1'b1) begin errors++; $display("FAIL single_stb: got %b, need 1", b1.output_stb); end
        if (b1.output_data !== 32'h0000_00A5) begin errors++; $display("FAIL single_data: got %h, need 000000a5", b1.output_data); end
        if (b1.output_channel !== 2'd1) begin errors++; $display("FAIL single_channel: got %0d, need 1", b1.output_channel); end
        if (b1.input_ack !== '0) begin errors++; $display("FAIL single_ack_drop: got %b, need 0", b1.input_ack); end
    endtask

    task automatic test_round_robin();
        int exp_ch [6] = '{0, 1, 2, 3, 0, 1};
        int used [C];
        do_reset();
        for (int k = 0; k < C; k++) begin
            used[k] = 0;
            for (int n = 0; n < 6; n++) pq[k].push_back($urandom);
            sw[k] = pq[k];
            en[k] = 1'b1;
        end
        oack[0] = 1'b1;
        run_until(0, 6, 200, "round_robin");
        for (int j = 0; j < 6 && j < rx_ch[0].size(); j++) begin
            checks++;
            if (rx_ch[0][j] != exp_ch[j] || rx_dat[0][j] !== sw[exp_ch[j]][used[exp_ch[j]]]) begin
                errors++;
                $display("FAIL round_robin[%0d]: ch=%0d data=%h, need %0d %h", j, rx_ch[0][j],
                         rx_dat[0][j], exp_ch[j], sw[exp_ch[j]][used[exp_ch[j]]]);
            end
            used[exp_ch[j]]++;
        end
    endtask

    task automatic test_burst();
        int exp_ch [9] = '{0, 0, 0, 2, 2, 2, 0, 0, 0};
        int used [C];
        do_reset();
        for (int k = 0; k < C; k++) used[k] = 0;
        for (int n = 0; n < 9; n++) begin
            pq[C+0].push_back($urandom);
            pq[C+2].push_back($urandom);
        end
        sw[C+0] = pq[C+0];
        sw[C+2] = pq[C+2];
        en[C+0] = 1'b1;
        en[C+2] = 1'b1;
        oack[1] = 1'b1;
        run_until(1, 9, 300, "burst");
        for (int j = 0; j < 9 && j < rx_ch[1].size(); j++) begin
            checks++;
            if (rx_ch[1][j] != exp_ch[j] || rx_dat[1][j] !== sw[C+exp_ch[j]][used[exp_ch[j]]]) begin
                errors++;
                $display("FAIL burst[%0d]: ch=%0d data=%h, need %0d %h", j, rx_ch[1][j],
                         rx_dat[1][j], exp_ch[j], sw[C+exp_ch[j]][used[exp_ch[j]]]);
            end
            used[exp_ch[j]]++;
        end
    endtask

    task automatic test_backpressure();
        int exp_ch [4] = '{0, 1, 0, 1};
        int cyc;
        logic [W-1:0] held;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            pq[k].push_back($urandom);
            pq[k].push_back($urandom);
            sw[k] = pq[k];
            en[k] = 1'b1;
        end
        cyc = 0;
        while (b1.output_stb !== 1'b1 && cyc < 10) begin step(); cyc++; end
        checks++;
        if (b1.output_stb !== 1'b1) begin errors++; $display("FAIL bp_start_timeout: output_stb=%b, need 1", b1.output_stb); end
        held = b1.output_data;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (b1.output_stb !== 1'b1 || b1.output_data !== held || b1.input_ack !== '0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: stb=%b data=%h ack=%b, need 1 %h 0000", i,
                         b1.output_stb, b1.output_data, b1.input_ack, held);
            end
        end
        oack[0] = 1'b1;
        step();
        checks++;
        if (rx_ch[0].size() != 1 || rx_dat[0][0] !== sw[0][0]) begin
            errors++;
            $display("FAIL bp_release: got %0d words, need 1 word %h", rx_ch[0].size(), sw[0][0]);
        end
        run_until(0, 4, 100, "bp_resume");
        for (int j = 0; j < 4 && j < rx_ch[0].size(); j++) begin
            checks++;
            if (rx_ch[0][j] != exp_ch[j] || rx_dat[0][j] !== sw[exp_ch[j]][j/2]) begin
                errors++;
                $display("FAIL bp_order[%0d]: ch=%0d data=%h, need %0d %h", j, rx_ch[0][j],
                         rx_dat[0][j], exp_ch[j], sw[exp_ch[j]][j/2]);
            end
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        pq[3].push_back(32'h3333_0003);
        pq[0].push_back(32'h0000_0A00);
        en[3] = 1'b1;
        oack[0] = 1'b1;
        step();
        checks++;
        if (b1.input_ack !== 4'b1000) begin errors++; $display("FAIL wd_grant: got %b, need 1000", b1.input_ack); end
        en[3] = 1'b0;
        en[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (b1.input_ack !== 4'b1000 || b1.output_stb !== 1'b0) begin
                errors++;
                $display("FAIL wd_hold[%0d]: ack=%b stb=%b, need 1000 0", i, b1.input_ack, b1.output_stb);
            end
        end
        en[3] = 1'b1;
        run_until(0, 2, 50, "withdraw");
        if (rx_ch[0].size() >= 2) begin
            checks += 2;
            if (rx_ch[0][0] != 3 || rx_dat[0][0] !== 32'h3333_0003) begin
                errors++;
                $display("FAIL wd_first: ch=%0d data=%h, need 3 33330003", rx_ch[0][0], rx_dat[0][0]);
            end
            if (rx_ch[0][1] != 0 || rx_dat[0][1] !== 32'h0000_0A00) begin
                errors++;
                $display("FAIL wd_second: ch=%0d data=%h, need 0 00000a00", rx_ch[0][1], rx_dat[0][1]);
            end
        end
    endtask

    // Reference: every channel requests from the start, so grants follow the
    // pointer rule alone; each grant takes min(BURST, words left) words.
    task automatic test_random();
        int total [2];
        int rem [C];
        int used [C];
        int exp_ch [$];
        int p, k, take, budget;
        bit busy;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int d = 0; d < 2; d++) begin
                total[d] = 0;
                for (int c = 0; c < C; c++) begin
                    int n = $urandom_range(0, 5);
                    for (int i = 0; i < n; i++) pq[d*C+c].push_back($urandom);
                    sw[d*C+c] = pq[d*C+c];
                    en[d*C+c] = 1'b1;
                    total[d] += n;
                end
            end
            budget = 0;
            busy = 1'b1;
            while (busy && budget < 2000) begin
                oack[0] = 1'($urandom_range(0, 1));
                oack[1] = 1'($urandom_range(0, 1));
                step();
                budget++;
                busy = (rx_ch[0].size() < total[0]) || (rx_ch[1].size() < total[1]);
            end
            for (int d = 0; d < 2; d++) begin
                exp_ch.delete();
                for (int c = 0; c < C; c++) begin
                    rem[c] = sw[d*C+c].size();
                    used[c] = 0;
                end
                p = 0;
                for (int g = 0; g < total[d]; ) begin
                    k = -1;
                    for (int i = C - 1; i >= 0; i--) begin
                        if (rem[(p + i) % C] > 0) k = (p + i) % C;
                    end
                    take = (rem[k] < ((d == 0) ? 1 : 3)) ? rem[k] : ((d == 0) ? 1 : 3);
                    for (int t = 0; t < take; t++) exp_ch.push_back(k);
                    rem[k] -= take;
                    g += take;
                    p = (k + 1) % C;
                end
                checks++;
                if (rx_ch[d].size() != total[d]) begin
                    errors++;
                    $display("FAIL rand_count r%0d dut%0d: got %0d words, need %0d", round, d,
                             rx_ch[d].size(), total[d]);
                end
                for (int j = 0; j < total[d] && j < rx_ch[d].size(); j++) begin
                    checks++;
                    if (rx_ch[d][j] != exp_ch[j] || rx_dat[d][j] !== sw[d*C+exp_ch[j]][used[exp_ch[j]]]) begin
                        errors++;
                        $display("FAIL rand_word r%0d dut%0d[%0d]: ch=%0d data=%h, need %0d %h", round, d, j,
                                 rx_ch[d][j], rx_dat[d][j], exp_ch[j], sw[d*C+exp_ch[j]][used[exp_ch[j]]]);
                    end
                    used[exp_ch[j]]++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        b1.input_stb = '0; b1.input_data = '0; b1.output_ack = 1'b0;
        b3.input_stb = '0; b3.input_data = '0; b3.output_ack = 1'b0;
        clear_all();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_backpressure();
        test_withdraw();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
